// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the video RAM arbiter: VRAM geometry, CPU-side FSM
// state codes and the blanking-window helper.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // True when the CPU may use a free RAM cycle given the raster window.
    function automatic logic cpu_window(input logic blank_only, input logic vid_active);
        return !blank_only || !vid_active;
    endfunction

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: raster fetch always wins the address bus; CPU
// accesses are slotted into free cycles with a req/ack handshake.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter bit BLANK_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_active,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic              vid_valid_reg;
    logic              op_read_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;

    logic              grant;
    logic              ack_now;
    logic              read_ack;

    // Reset gates the grant so a request held through reset can never write.
    assign grant = (state_reg == ST_IDLE) && cpu_req && !vid_req &&
                   cpu_window(BLANK_ONLY, vid_active) && !reset;

    assign ack_now  = (state_reg == ST_DATA) && !reset;
    assign read_ack = ack_now && op_read_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (grant)    state_next = ST_DATA;
            ST_DATA:                  state_next = ST_RELEASE;
            ST_RELEASE: if (!cpu_req) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Address mux: raster first, then a granted CPU access, else hold the bus.
    always_comb begin
        ram_addr = addr_hold_reg;
        if (reset) begin
            ram_addr = '0;
        end else if (vid_req) begin
            ram_addr = vid_addr;
        end else if (grant) begin
            ram_addr = cpu_addr;
        end
    end

    assign ram_we    = grant && cpu_we;
    assign ram_wdata = cpu_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_reg <= '0;
            vid_valid_reg <= 1'b0;
            op_read_reg   <= 1'b0;
            cpu_rdata_reg <= '0;
        end else begin
            addr_hold_reg <= ram_addr;
            vid_valid_reg <= vid_req;
            if (grant) begin
                op_read_reg <= !cpu_we;
            end
            if (read_ack) begin
                cpu_rdata_reg <= ram_rdata;
            end
        end
    end

    assign vid_valid = vid_valid_reg;
    assign vid_rdata = ram_rdata;
    assign cpu_ack   = ack_now;

    // RAM data arrives in the ack cycle itself, so pass it through then and
    // hold the captured copy afterwards.
    assign cpu_rdata = read_ack ? ram_rdata : cpu_rdata_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: one instance per BLANK_ONLY setting on shared
// stimulus, each with its own RAM, checked every cycle against a reference model.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_active;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;

    logic          d_vv     [NI];
    logic [DW-1:0] d_vd     [NI];
    logic          d_ack    [NI];
    logic [DW-1:0] d_crd    [NI];
    logic [AW-1:0] d_raddr  [NI];
    logic          d_rwe    [NI];
    logic [DW-1:0] d_rwdata [NI];

    function automatic logic [DW-1:0] init_val(input int a);
        logic [31:0] v;
        v = a ^ (a >> 5) ^ 32'h3C;
        return v[DW-1:0];
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : gen_dut
        logic [DW-1:0] mem [0:8191];
        logic [DW-1:0] q;

        initial begin
            for (int a = 0; a < 8192; a++) mem[a] = init_val(a);
        end

        always @(posedge clk) begin
            if (d_rwe[gi]) mem[d_raddr[gi]] <= d_rwdata[gi];
            q <= mem[d_raddr[gi]];
        end

        vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLANK_ONLY(gi == 1)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .vid_req    (vid_req),
            .vid_addr   (vid_addr),
            .vid_active (vid_active),
            .vid_valid  (d_vv[gi]),
            .vid_rdata  (d_vd[gi]),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .cpu_ack    (d_ack[gi]),
            .cpu_rdata  (d_crd[gi]),
            .ram_addr   (d_raddr[gi]),
            .ram_we     (d_rwe[gi]),
            .ram_wdata  (d_rwdata[gi]),
            .ram_rdata  (q)
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, expressed as pending events rather than FSM states.
    logic [DW-1:0] ref_mem [NI][8192];
    bit            checking;
    bit            exp_vv      [NI];
    logic [DW-1:0] exp_vd      [NI];
    bit            exp_ack     [NI];
    bit            exp_ack_rd  [NI];
    logic [DW-1:0] exp_ack_dat [NI];
    logic [DW-1:0] held        [NI];
    bit            can_grant   [NI];
    bit            waiting     [NI];
    logic [AW-1:0] last_addr   [NI];

    logic          s_vv   [NI];
    logic [DW-1:0] s_vd   [NI];
    logic          s_ack  [NI];
    logic [DW-1:0] s_crd  [NI];
    logic [AW-1:0] s_addr [NI];
    logic          s_we   [NI];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    task automatic check_cond(input string name, input int inst, input bit ok, input int act);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: observed %0d out of range", name, inst, $time, act);
        end
    endtask

    task automatic model_step();
        bit            gnt;
        bit            e_we;
        bit            e_ack;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_crd;
        for (int i = 0; i < NI; i++) begin
            s_vv[i]   = d_vv[i];
            s_vd[i]   = d_vd[i];
            s_ack[i]  = d_ack[i];
            s_crd[i]  = d_crd[i];
            s_addr[i] = d_raddr[i];
            s_we[i]   = d_rwe[i];

            gnt    = !reset && can_grant[i] && cpu_req && !vid_req && (i == 0 || !vid_active);
            e_addr = reset ? '0 : vid_req ? vid_addr : gnt ? cpu_addr : last_addr[i];
            e_we   = gnt && cpu_we;
            e_ack  = exp_ack[i] && !reset;
            e_crd  = (e_ack && exp_ack_rd[i]) ? exp_ack_dat[i] : held[i];

            if (checking) begin
                check("ram_addr", i, 32'(s_addr[i]), 32'(e_addr));
                check("ram_we", i, 32'(s_we[i]), 32'(e_we));
                check("cpu_ack", i, 32'(s_ack[i]), 32'(e_ack));
                check("cpu_rdata", i, 32'(s_crd[i]), 32'(e_crd));
                check("vid_valid", i, 32'(s_vv[i]), 32'(exp_vv[i]));
                if (exp_vv[i]) check("vid_rdata", i, 32'(s_vd[i]), 32'(exp_vd[i]));
            end

            if (reset) begin
                exp_vv[i]    = 1'b0;
                exp_ack[i]   = 1'b0;
                held[i]      = '0;
                can_grant[i] = 1'b1;
                waiting[i]   = 1'b0;
                last_addr[i] = '0;
            end else begin
                if (e_ack) begin
                    held[i]    = e_crd;
                    waiting[i] = 1'b1;
                end else if (waiting[i] && !cpu_req) begin
                    waiting[i]   = 1'b0;
                    can_grant[i] = 1'b1;
                end
                exp_vv[i]  = vid_req;
                exp_vd[i]  = ref_mem[i][vid_addr];
                exp_ack[i] = gnt;
                if (gnt) begin
                    exp_ack_rd[i]  = !cpu_we;
                    exp_ack_dat[i] = ref_mem[i][cpu_addr];
                    can_grant[i]   = 1'b0;
                end
                if (e_we) ref_mem[i][cpu_addr] = cpu_wdata;
                last_addr[i] = e_addr;
            end
        end
        if (reset) checking = 1'b1;
    endtask

    // Inputs set before tick() apply to one full clock cycle.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bit done;
        done      = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        for (int k = 0; k < 8 && !done; k++) begin
            tick();
            done = s_ack[0];
        end
        check("access_done", 0, 32'(done), 32'd1);
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        int acks;
        int wes;
        int start;
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 8192; a++) ref_mem[i][a] = init_val(a);
        checking   = 1'b0;
        reset      = 1'b1;
        vid_req    = 1'b0;
        vid_addr   = '0;
        vid_active = 1'b0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 13'h0100;
        cpu_wdata  = 8'h77;

        // 1: reset with a write request held
        for (int k = 0; k < 3; k++) begin
            if (k == 2) cpu_req = 1'b0;
            tick();
            check("rst_we", 0, 32'(s_we[0]), 32'd0);
            check("rst_ack", 0, 32'(s_ack[0]), 32'd0);
        end
        reset = 1'b0;
        tick();
        check("idle_addr", 0, 32'(s_addr[0]), 32'd0);

        // 2: write then read back on an idle bus
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1234; cpu_wdata = 8'hA5;
        tick();
        check("wr_we_T", 0, 32'(s_we[0]), 32'd1);
        check("wr_addr_T", 0, 32'(s_addr[0]), 32'h1234);
        tick();
        check("wr_ack_T1", 0, 32'(s_ack[0]), 32'd1);
        cpu_req = 1'b0;
        tick();
        cpu_access(1'b0, 13'h1234, 8'h00);
        check("rd_1234", 0, 32'(d_crd[0]), 32'hA5);
        cpu_access(1'b1, 13'h1FFF, 8'hC3);
        cpu_access(1'b0, 13'h1FFF, 8'h00);
        check("rd_wrap", 1, 32'(d_crd[1]), 32'hC3);

        // 3: raster and CPU collide
        vid_req = 1'b1; vid_addr = 13'h0028;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0000;
        tick();
        check("col_addr", 0, 32'(s_addr[0]), 32'h0028);
        check("col_we", 0, 32'(s_we[0]), 32'd0);
        vid_req = 1'b0;
        tick();
        check("col_vv", 0, 32'(s_vv[0]), 32'd1);
        check("col_vd", 0, 32'(s_vd[0]), 32'h15);
        check("col_grant", 0, 32'(s_addr[0]), 32'h0000);
        tick();
        check("col_ack", 0, 32'(s_ack[0]), 32'd1);
        check("col_rdata", 0, 32'(s_crd[0]), 32'h3C);
        cpu_req = 1'b0;
        tick();

        // 4: raster every 8 clocks with back-to-back CPU reads
        acks  = 0;
        start = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            vid_req  = (cyc % 8 == 2);
            vid_addr = 13'(13'h0400 + cyc);
            tick();
            if (cpu_req && s_ack[0]) begin
                acks++;
                check_cond("ack_lat", 0, (cyc - start) <= 2, cyc - start);
                cpu_req = 1'b0;
            end else if (!cpu_req) begin
                cpu_req  = 1'b1;
                cpu_we   = 1'b0;
                cpu_addr = 13'(13'h1230 + acks);
                start    = cyc + 1;
            end
        end
        vid_req = 1'b0;
        check_cond("ack_count", 0, acks >= 10, acks);
        if (cpu_req) begin
            for (int k = 0; k < 3 && !s_ack[0]; k++) tick();
            cpu_req = 1'b0;
        end
        tick();
        tick();

        // 5: blanking-only instance waits for vid_active to fall
        vid_active = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0555; cpu_wdata = 8'h5A;
        tick();
        check("bo0_we", 0, 32'(s_we[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("bo1_no_we", 1, 32'(s_we[1]), 32'd0);
            check("bo1_no_ack", 1, 32'(s_ack[1]), 32'd0);
            tick();
        end
        vid_active = 1'b0;
        tick();
        check("bo1_we", 1, 32'(s_we[1]), 32'd1);
        tick();
        check("bo1_ack", 1, 32'(s_ack[1]), 32'd1);
        cpu_req = 1'b0;
        tick();
        tick();

        // 6: request held after ack, then reset during the data phase
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0ABC; cpu_wdata = 8'h3C;
        acks = 0;
        wes  = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            acks += int'(s_ack[0]);
            wes  += int'(s_we[0]);
        end
        check("held_acks", 0, 32'(acks), 32'd1);
        check("held_wes", 0, 32'(wes), 32'd1);
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0DEF; cpu_wdata = 8'hEE;
        tick();
        reset = 1'b1;
        tick();
        check("rst_data_ack", 0, 32'(s_ack[0]), 32'd0);
        reset   = 1'b0;
        cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_we", 0, 32'(s_we[0]), 32'd0);
        end
        cpu_access(1'b0, 13'h0DEF, 8'h00);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
